toggle_enable_debounce: RTL and testbench

Conditions a raw, bouncy push-button input into a clean single-cycle `enable` pulse for the `flip_flop_T` stage, which sits directly downstream. The block synchronises the asynchronous button and debounces both press and release with a cycle counter. It emits exactly one `enable` pulse per accepted press, so `qt` toggles once per press. It also exports the debounced button level and a busy flag for observation.

---
 rtl/toggle_enable_debounce.sv | 121 ++++++++++++
 tb/tb_toggle_enable_debounce.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_enable_debounce.sv
// toggle_enable_debounce
//
// Turns a raw, bouncy push-button into a clean one-cycle enable pulse for the
// flip_flop_T stage downstream, so the toggle output flips exactly once per
// physical press. Both the press and the release are debounced: a new level
// is accepted only after the synchronised button has held it for DB_CYCLES
// cycles beyond the first sighting.
//
// Parameters
//   DB_CYCLES  stable synchronised cycles needed to accept a press/release
//              (1 .. 2**CNT_W)
//   CNT_W      width of the debounce counter
//
// Ports
//   clock   in   single clock, rising-edge
//   reset   in   synchronous, active-high reset
//   btn     in   raw button, asynchronous to clock, may bounce
//   enable  out  registered one-cycle pulse per accepted press
//   level   out  debounced button level (1 in HELD/DISARM)
//   busy    out  1 whenever the FSM is away from IDLE

module toggle_enable_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic enable,
  output logic level,
  output logic busy
);

  // The encoding is fixed so that bit 1 is directly the debounced level.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM    = 2'b01,
    HELD   = 2'b10,
    DISARM = 2'b11
  } state_t;

  // Terminal count: the counter only ever reaches DB_CYCLES-1, so it never
  // wraps even when DB_CYCLES equals 2**CNT_W.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DB_CYCLES - 1);

  state_t           state;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser. btn is asynchronous, so s1 may go metastable;
  // only s2 is allowed to feed the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce FSM. ARM counts stable highs before accepting a press, DISARM
  // counts stable lows before accepting a release. Any contrary sample in
  // ARM/DISARM falls back to the previous stable state, which is what
  // swallows contact bounce. enable is registered here and defaults to 0
  // on every edge, so it can only be high for the single cycle following
  // the ARM->HELD transition; reset clears it on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      enable <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= ARM;
            cnt   <= '0;
          end
        end
        ARM: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == LAST_CNT) begin
            state  <= HELD;
            enable <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state <= DISARM;
            cnt   <= '0;
          end
        end
        DISARM: begin
          if (s2) begin
            state <= HELD;
          end else if (cnt == LAST_CNT) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Observation outputs are pure decodes of the state register, so they
  // carry no extra latency and cannot glitch between states.
  assign level = state[1];
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_toggle_enable_debounce.sv
// tb_toggle_enable_debounce
//
// Drives three instances of toggle_enable_debounce (DB_CYCLES = 4, 1 and 8)
// from one shared button/reset. A table of clean-press vectors and a few
// hand-written corner sequences are checked against fixed timing figures;
// a long random run is checked against a run-length reference model.

module tb_toggle_enable_debounce;

  logic clock = 1'b0;
  logic reset;
  logic btn;

  logic en4, lv4, bz4;
  logic en1, lv1, bz1;
  logic en8, lv8, bz8;

  logic qt;

  int compared   = 0;
  int mismatched = 0;

  // Clock generation
  always #5 clock = ~clock;

  toggle_enable_debounce #(.DB_CYCLES(4), .CNT_W(3)) dut4 (
    .clock (clock),
    .reset (reset),
    .btn   (btn),
    .enable(en4),
    .level (lv4),
    .busy  (bz4)
  );

  toggle_enable_debounce #(.DB_CYCLES(1), .CNT_W(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .btn   (btn),
    .enable(en1),
    .level (lv1),
    .busy  (bz1)
  );

  toggle_enable_debounce #(.DB_CYCLES(8), .CNT_W(3)) dut8 (
    .clock (clock),
    .reset (reset),
    .btn   (btn),
    .enable(en8),
    .level (lv8),
    .busy  (bz8)
  );

  // Downstream toggle stage, standing in for flip_flop_T
  always_ff @(posedge clock) begin
    if (reset) qt <= 1'b0;
    else if (en4) qt <= ~qt;
  end

  // Reference model: a new level is accepted once the synchronised button
  // has disagreed with the current debounced level for DB+1 consecutive
  // edges; any agreeing sample clears the run.
  int   mdb[3] = '{4, 1, 8};
  logic pipe0, pipe1;
  logic mLvl[3];
  int   mRun[3];
  logic mEn[3];

  task automatic modelStep(input logic r, input logic b);
    logic bs;
    if (r) begin
      pipe0 = 1'b0;
      pipe1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
        mLvl[i] = 1'b0;
        mRun[i] = 0;
        mEn[i]  = 1'b0;
      end
    end else begin
      bs    = pipe1;
      pipe1 = pipe0;
      pipe0 = b;
      for (int i = 0; i < 3; i++) begin
        mEn[i] = 1'b0;
        if (bs != mLvl[i]) mRun[i] = mRun[i] + 1;
        else mRun[i] = 0;
        if (mRun[i] == mdb[i] + 1) begin
          mLvl[i] = bs;
          mRun[i] = 0;
          mEn[i]  = bs;
        end
      end
    end
  endtask

  function automatic int modelOut(input int i);
    logic busyM;
    busyM = mLvl[i] | (mRun[i] > 0);
    return int'({mEn[i], mLvl[i], busyM});
  endfunction

  // One clock edge with the given inputs; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic r, input logic b);
    reset = r;
    btn   = b;
    @(posedge clock);
    modelStep(r, b);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic b;
    logic expEn;
    logic expLv;
    logic expBz;
  } vec_t;

  vec_t cleanTable[40];

  // Main test sequence
  initial begin
    int firstEn4, firstEn1, firstEn8, pulses, runLen;
    logic cur;
    logic [2:0] qtExp;

    // Clean press: btn first sampled high at edge 10, low again at edge 30
    for (int i = 0; i < 40; i++) begin
      cleanTable[i].b     = (i >= 10 && i < 30);
      cleanTable[i].expEn = (i == 16);
      cleanTable[i].expLv = (i >= 16 && i < 36);
      cleanTable[i].expBz = (i >= 12 && i < 36);
    end

    reset = 1'b1;
    btn   = 1'b0;

    // Reset held with the button pressed: everything stays quiet
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("reset_outputs", int'({en4, lv4, bz4}), 0);
    end
    // Button still held: a full debounce runs, first non-reset edge is k=1
    firstEn4 = -1; firstEn1 = -1; firstEn8 = -1;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b0, 1'b1);
      if (en4 && firstEn4 < 0) firstEn4 = e;
      if (en1 && firstEn1 < 0) firstEn1 = e;
      if (en8 && firstEn8 < 0) firstEn8 = e;
    end
    checkOutput("post_reset_first_enable_db4", firstEn4, 1 + 4 + 2);
    checkOutput("post_reset_first_enable_db1", firstEn1, 1 + 1 + 2);
    checkOutput("post_reset_first_enable_db8", firstEn8, 1 + 8 + 2);

    // Table-driven clean press and release
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, cleanTable[i].b);
      checkOutput($sformatf("clean_edge%0d", i), int'({en4, lv4, bz4}),
                  int'({cleanTable[i].expEn, cleanTable[i].expLv, cleanTable[i].expBz}));
    end

    // Press bounce: too short a high run each time, never accepted
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      logic [6:0] pat;
      pat = 7'b0111011;
      applyStimulus(1'b0, (i < 7) ? pat[i] : 1'b0);
      checkOutput($sformatf("press_bounce_edge%0d", i), int'({en4, lv4}), 0);
    end

    // Release bounce: drop back to HELD once, then a clean release
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("release_bounce_held", int'(lv4), 1);
    for (int j = 0; j < 14; j++) begin
      applyStimulus(1'b0, (j == 2));
      checkOutput($sformatf("release_bounce_edge%0d", j), int'({en4, lv4, bz4}),
                  (j < 9) ? 3 : 0);
    end

    // Three presses into the toggle stage
    applyStimulus(1'b1, 1'b0);
    pulses = 0;
    qtExp  = 3'b101;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        applyStimulus(1'b0, (i < 10));
        if (en4) pulses++;
      end
      checkOutput($sformatf("toggle_qt_press%0d", p), int'(qt), int'(qtExp[p]));
    end
    checkOutput("toggle_pulse_count", pulses, 3);

    // Reset in the middle of ARM, button kept pressed
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("mid_arm_busy", int'({en4, lv4, bz4}), 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_arm_reset_outputs", int'({en4, lv4, bz4}), 0);
    firstEn4 = -1;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b0, 1'b1);
      if (en4 && firstEn4 < 0) firstEn4 = e;
    end
    checkOutput("mid_arm_refire_edge", firstEn4, 1 + 4 + 2);

    // Random bouncy button with occasional resets, against the model
    applyStimulus(1'b1, 1'b0);
    cur = 1'b0;
    runLen = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r;
      if (runLen == 0) begin
        cur    = ~cur;
        runLen = $urandom_range(1, 13);
      end
      runLen--;
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(r, cur);
      checkOutput("random_db4", int'({en4, lv4, bz4}), modelOut(0));
      checkOutput("random_db1", int'({en1, lv1, bz1}), modelOut(1));
      checkOutput("random_db8", int'({en8, lv8, bz8}), modelOut(2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
